// File: rtl/sync_debounce.sv
// Synchronizer plus stable-level debouncer feeding a downstream storage flop.
// Optional rise/fall edge pulses are compiled in with SYNC_DEBOUNCE_EDGE_EN.
module sync_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic dout_b,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   dout_q;
  logic                   dout_b_q;
  logic                   s;
  logic                   differ;
  logic                   accept;

  // Plain shift chain: no logic between stages so every stage can resolve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign differ = s ^ dout_q;
  assign accept = (state_q == StCount) && differ && (cnt_q == CntLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      dout_b_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (differ) begin
            state_q <= StCount;
            cnt_q   <= CNT_W'(1);
          end
        end
        StCount: begin
          if (!differ) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (accept) begin
            // Terminal compare clears the counter, so it can never wrap.
            state_q  <= StIdle;
            cnt_q    <= '0;
            dout_q   <= s;
            dout_b_q <= ~s;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign dout   = dout_q;
  assign dout_b = dout_b_q;
  assign busy   = (state_q == StCount);

`ifdef SYNC_DEBOUNCE_EDGE_EN
  logic rise_q;
  logic fall_q;

  // Pulses share the accept edge with dout, so they line up with the new level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept & s;
      fall_q <= accept & ~s;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce at default parameters; edge-pulse
// expectations follow SYNC_DEBOUNCE_EDGE_EN.
module tb_sync_debounce;

`ifdef SYNC_DEBOUNCE_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic clk;
  logic reset;
  logic din;
  logic dout;
  logic dout_b;
  logic rise;
  logic fall;
  logic busy;
  logic clk_run;

  int checks;
  int errors;

  sync_debounce #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .dout  (dout),
    .dout_b(dout_b),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit d, input bit b, input bit r,
                            input bit f);
    check({tag, " dout"}, dout, d);
    check({tag, " dout_b"}, dout_b, ~d);
    check({tag, " busy"}, busy, b);
    check({tag, " rise"}, rise, r);
    check({tag, " fall"}, fall, f);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clk_run = 1'b0;
    reset   = 1'b0;
    din     = 1'b0;

    // Reset with the clock static.
    #2;
    reset = 1'b1;
    din   = 1'b1;
    #1;
    check_outs("reset_static", 1'b0, 1'b0, 1'b0, 1'b0);
    clk_run = 1'b1;
    tick();
    tick();
    check_outs("reset_clocked", 1'b0, 1'b0, 1'b0, 1'b0);

    // Accepted rise: din already high, counted from the first edge after release.
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_outs($sformatf("rise_e%0d", e), e >= 6, (e >= 3) && (e <= 5),
                 EdgeEn && (e == 6), 1'b0);
    end

    // Accepted fall.
    din = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_outs($sformatf("fall_e%0d", e), e < 6, (e >= 3) && (e <= 5), 1'b0,
                 EdgeEn && (e == 6));
    end

    // Glitch of DEBOUNCE_CYCLES-1 cycles is rejected.
    din = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check_outs($sformatf("glitch_e%0d", e), 1'b0, (e >= 3) && (e <= 5), 1'b0, 1'b0);
      if (e == 3) din = 1'b0;
    end

    // Pulse between edges never reaches the chain, so busy stays low.
    #1 din = 1'b1;
    #2 din = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check_outs($sformatf("short_e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Pulse of exactly DEBOUNCE_CYCLES is accepted, then falls back.
    din = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check_outs($sformatf("minpulse_e%0d", e), (e >= 6) && (e <= 9),
                 ((e >= 3) && (e <= 5)) || ((e >= 7) && (e <= 9)),
                 EdgeEn && (e == 6), EdgeEn && (e == 10));
      if (e == 4) din = 1'b0;
    end

    // Reset during qualification discards it.
    din = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check_outs($sformatf("precnt_e%0d", e), 1'b0, e >= 3, 1'b0, 1'b0);
    end
    #2 reset = 1'b1;
    #1;
    check_outs("midreset_async", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_outs("midreset_held", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_outs($sformatf("requal_e%0d", e), e >= 6, (e >= 3) && (e <= 5),
                 EdgeEn && (e == 6), 1'b0);
    end

    // Reset with dout high clears it immediately, keeping the pair complementary.
    #2 reset = 1'b1;
    #1;
    check_outs("reset_dout_hi", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    din   = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check_outs($sformatf("quiet_e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
